// File: rtl/wb_ic_pkg.sv
// Shared FSM state encodings and fault codes for the Wishbone interconnect.
package wb_ic_pkg;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DECODE = 2'd1;
  localparam state_t ST_ACTIVE = 2'd2;
  localparam state_t ST_RESP   = 2'd3;

  typedef logic [1:0] fault_t;
  localparam fault_t FAULT_NONE    = 2'd0;
  localparam fault_t FAULT_MISS    = 2'd1;
  localparam fault_t FAULT_TIMEOUT = 2'd2;
  localparam fault_t FAULT_SLVERR  = 2'd3;

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational prefix-match address decoder; one-hot select, lowest matching index wins.
module wb_addr_decode #(
  parameter int NUM_SLAVES = 4,
  parameter int AW         = 32,
  parameter logic [NUM_SLAVES*AW-1:0] SLAVE_ADDR = '0,
  parameter logic [NUM_SLAVES*AW-1:0] SLAVE_MASK = '0
) (
  input  logic [AW-1:0]         adr,
  output logic [NUM_SLAVES-1:0] sel
);

  // Walk from the top so a lower-index match overwrites any higher one.
  always_comb begin
    sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((adr & SLAVE_MASK[i*AW +: AW]) == (SLAVE_ADDR[i*AW +: AW] & SLAVE_MASK[i*AW +: AW]))
        sel = NUM_SLAVES'(1) << i;
    end
  end

endmodule

// File: rtl/wb_interconnect_n.sv
// Single-master, N-slave Wishbone classic interconnect with registered decode,
// bus-timeout watchdog, decode-miss errors and a sticky fault register.
module wb_interconnect_n
  import wb_ic_pkg::*;
#(
  parameter int NUM_SLAVES      = 4,
  parameter int WB_DATA_WIDTH   = 32,
  parameter int WB_ADDR_WIDTH   = 32,
  parameter int WB_SELECT_WIDTH = WB_DATA_WIDTH / 8,
  parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_ADDR =
    {32'h300, 32'h200, 32'h100, 32'h000},
  parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_MASK = {4{32'hFFFF_FF00}},
  parameter int TIMEOUT = 255
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [WB_ADDR_WIDTH-1:0]              wbm_adr_i,
  input  logic [WB_DATA_WIDTH-1:0]              wbm_dat_i,
  output logic [WB_DATA_WIDTH-1:0]              wbm_dat_o,
  input  logic                                  wbm_we_i,
  input  logic [WB_SELECT_WIDTH-1:0]            wbm_sel_i,
  input  logic                                  wbm_stb_i,
  input  logic                                  wbm_cyc_i,
  output logic                                  wbm_ack_o,
  output logic                                  wbm_err_o,
  output logic                                  wbm_rty_o,
  output logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0]   wbs_adr_o,
  output logic [NUM_SLAVES*WB_DATA_WIDTH-1:0]   wbs_dat_o,
  input  logic [NUM_SLAVES*WB_DATA_WIDTH-1:0]   wbs_dat_i,
  output logic [NUM_SLAVES-1:0]                 wbs_we_o,
  output logic [NUM_SLAVES*WB_SELECT_WIDTH-1:0] wbs_sel_o,
  output logic [NUM_SLAVES-1:0]                 wbs_stb_o,
  output logic [NUM_SLAVES-1:0]                 wbs_cyc_o,
  input  logic [NUM_SLAVES-1:0]                 wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]                 wbs_err_i,
  input  logic [NUM_SLAVES-1:0]                 wbs_rty_i,
  output logic [WB_ADDR_WIDTH-1:0]              o_fault_addr,
  output logic [1:0]                            o_fault_code,
  input  logic                                  i_fault_clr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t                       state;
  logic [WB_ADDR_WIDTH-1:0]     adr_q;
  logic [WB_DATA_WIDTH-1:0]     dat_q;
  logic                         we_q;
  logic [WB_SELECT_WIDTH-1:0]   sel_q;
  logic [NUM_SLAVES-1:0]        slv_sel;
  logic [NUM_SLAVES-1:0]        dec_sel;
  logic [CW-1:0]                cnt;
  logic [WB_DATA_WIDTH-1:0]     sel_dat;
  logic                         sel_ack;
  logic                         sel_err;
  logic                         sel_rty;

  wb_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .AW         (WB_ADDR_WIDTH),
    .SLAVE_ADDR (SLAVE_ADDR),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decode (
    .adr (wbm_adr_i),
    .sel (dec_sel)
  );

  assign wbs_adr_o = {NUM_SLAVES{adr_q}};
  assign wbs_dat_o = {NUM_SLAVES{dat_q}};
  assign wbs_we_o  = {NUM_SLAVES{we_q}};
  assign wbs_sel_o = {NUM_SLAVES{sel_q}};

  // Strobe follows the state register so it drops on the edge the response is captured.
  assign wbs_stb_o = (state == ST_ACTIVE) ? slv_sel : '0;
  assign wbs_cyc_o = (state == ST_ACTIVE) ? slv_sel : '0;

  assign sel_ack = |(wbs_ack_i & slv_sel);
  assign sel_err = |(wbs_err_i & slv_sel);
  assign sel_rty = |(wbs_rty_i & slv_sel);

  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (slv_sel[i])
        sel_dat = sel_dat | wbs_dat_i[i*WB_DATA_WIDTH +: WB_DATA_WIDTH];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      adr_q        <= '0;
      dat_q        <= '0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      slv_sel      <= '0;
      cnt          <= '0;
      wbm_dat_o    <= '0;
      wbm_ack_o    <= 1'b0;
      wbm_err_o    <= 1'b0;
      wbm_rty_o    <= 1'b0;
      o_fault_addr <= '0;
      o_fault_code <= FAULT_NONE;
    end else begin
      wbm_ack_o <= 1'b0;
      wbm_err_o <= 1'b0;
      wbm_rty_o <= 1'b0;
      // Clear first; any fault recorded below in the same cycle overrides it.
      if (i_fault_clr)
        o_fault_code <= FAULT_NONE;

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (wbm_cyc_i && wbm_stb_i) begin
            adr_q   <= wbm_adr_i;
            dat_q   <= wbm_dat_i;
            we_q    <= wbm_we_i;
            sel_q   <= wbm_sel_i;
            slv_sel <= dec_sel;
            state   <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          if (!wbm_cyc_i) begin
            state <= ST_IDLE;
          end else if (|slv_sel) begin
            state <= ST_ACTIVE;
          end else begin
            wbm_err_o    <= 1'b1;
            o_fault_code <= FAULT_MISS;
            o_fault_addr <= adr_q;
            state        <= ST_RESP;
          end
        end

        ST_ACTIVE: begin
          if (!wbm_cyc_i) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else if (sel_ack) begin
            wbm_dat_o <= sel_dat;
            wbm_ack_o <= 1'b1;
            state     <= ST_RESP;
          end else if (sel_err) begin
            wbm_err_o    <= 1'b1;
            o_fault_code <= FAULT_SLVERR;
            state        <= ST_RESP;
          end else if (sel_rty) begin
            wbm_rty_o <= 1'b1;
            state     <= ST_RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            wbm_err_o    <= 1'b1;
            o_fault_code <= FAULT_TIMEOUT;
            o_fault_addr <= adr_q;
            state        <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_RESP: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_interconnect_n.md
Name: wb_interconnect_n

Overview:
- Parametrised single-master, N-slave Wishbone classic interconnect; successor to the fixed three-slave mux between axis_wb_master and the peripheral slaves (wb_leds, wb_neoPx, blinktLEDBar).
- Adds a registered address decode, a per-transaction bus-timeout watchdog, and decode-miss error generation.
- Adds sticky fault reporting, so that a missing or hung slave cannot stall the serial bridge.

Parameters:
- NUM_SLAVES, 4, number of slave ports (1..16).
- WB_DATA_WIDTH, 32, data bus width in bits.
- WB_ADDR_WIDTH, 32, address bus width in bits.
- WB_SELECT_WIDTH, WB_DATA_WIDTH/8, byte-select width.
- SLAVE_ADDR, {32'h300,32'h200,32'h100,32'h000}, packed per-slave base addresses; slave i occupies bits [i*AW +: AW].
- SLAVE_MASK, {4{32'hFFFF_FF00}}, packed per-slave prefix masks.
- TIMEOUT, 255, number of cycles the block waits for a slave response before forcing an error; must be at least 1.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- wbm_adr_i  in  AW  master address
- wbm_dat_i  in  DW  master write data
- wbm_dat_o  out  DW  read data to master (registered)
- wbm_we_i  in  1  write enable
- wbm_sel_i  in  SW  byte select
- wbm_stb_i  in  1  strobe
- wbm_cyc_i  in  1  cycle
- wbm_ack_o  out  1  acknowledge (registered)
- wbm_err_o  out  1  error (registered)
- wbm_rty_o  out  1  retry (registered)
- wbs_adr_o  out  N*AW  per-slave address
- wbs_dat_o  out  N*DW  per-slave write data
- wbs_dat_i  in  N*DW  per-slave read data
- wbs_we_o  out  N  per-slave write enable
- wbs_sel_o  out  N*SW  per-slave byte select
- wbs_stb_o  out  N  per-slave strobe
- wbs_cyc_o  out  N  per-slave cycle
- wbs_ack_i  in  N  per-slave acknowledge
- wbs_err_i  in  N  per-slave error
- wbs_rty_i  in  N  per-slave retry
- o_fault_addr  out  AW  address of the most recent decode miss or timeout
- o_fault_code  out  2  fault code: 0 none, 1 decode miss, 2 timeout, 3 slave err
- i_fault_clr  in  1  clears o_fault_code to 0

Behaviour:
- Reset (i_rst high at a clock edge):
  - Next cycle: state IDLE; all wbs_stb_o and wbs_cyc_o = 0; wbm_ack_o, wbm_err_o, wbm_rty_o = 0.
  - wbm_dat_o = 0, o_fault_addr = 0, o_fault_code = 0, timeout counter = 0.
  - Reset taken mid-transaction abandons the transaction silently; the master receives no response.
- Pass-through: wbs_adr_o, wbs_dat_o, wbs_we_o and wbs_sel_o carry the latched master request, replicated to every slave. Only the selected slave sees stb and cyc.
- Decode: slave i matches when (adr & SLAVE_MASK[i]) == (SLAVE_ADDR[i] & SLAVE_MASK[i]). If several slaves match, the lowest index wins.
- State IDLE:
  - Response outputs held at 0.
  - On wbm_cyc_i & wbm_stb_i: latch adr, dat, we and sel; compute a one-hot select into a register; go to DECODE.
- State DECODE (exactly one cycle):
  - Select nonzero: go to ACTIVE with wbs_cyc_o[sel] and wbs_stb_o[sel] = 1 from the next cycle.
  - Select zero: go to RESP with wbm_err_o = 1; fault_code = 1; fault_addr = latched address.
- State ACTIVE:
  - Timeout counter increments every cycle.
  - Response priority when several are present in the same cycle: ack > err > rty.
  - Selected slave ack: capture wbs_dat_i[sel] into wbm_dat_o; wbm_ack_o = 1 next cycle; go to RESP.
  - Selected slave err: wbm_err_o = 1 next cycle; fault_code = 3; go to RESP.
  - Selected slave rty: wbm_rty_o = 1 next cycle; go to RESP.
  - Counter reaches TIMEOUT with no response: wbm_err_o = 1; fault_code = 2; fault_addr latched; go to RESP.
  - Slave strobe and cycle drop on the same edge that the response is registered.
  - Responses from non-selected slaves are ignored.
- State RESP:
  - Exactly one response pulse is high for one cycle; then go to IDLE with the counter cleared.
- Latency: master stb at cycle 0 → slave stb at cycle 2 → slave ack at cycle k ≥ 2 → wbm_ack_o at k+1.
- Master abort: wbm_cyc_i low in DECODE or ACTIVE → IDLE next cycle, slave stb and cyc dropped, no response, no fault recorded.
- Fault register:
  - Sticky; a new fault overwrites the previous one.
  - i_fault_clr zeroes the code; a fault recorded in the same cycle wins over the clear.

Decomposition:
- Package wb_ic_pkg: state enum (IDLE, DECODE, ACTIVE, RESP); fault-code constants FAULT_NONE, FAULT_MISS, FAULT_TIMEOUT, FAULT_SLVERR.
- Sub-module wb_addr_decode: combinational priority decoder; address in, N-bit one-hot select out.
- Top-level module holds the FSM, the watchdog counter and the response and fault registers.

Test Plan (NUM_SLAVES=4, default maps, TIMEOUT=16):
- Read 0x0000_0104, slave 1 acks 3 cycles after its stb with 0xDEADBEEF → wbm_ack_o pulses once, wbm_dat_o = 0xDEADBEEF; no other slave sees stb.
- Write 0x0000_0300, data 0x12 → only wbs_stb_o[3] asserted; wbs_dat_o slice 3 = 0x12; ack returned.
- Access 0x0000_0400 → wbm_err_o pulses in cycle 2; o_fault_code = 1; o_fault_addr = 0x400; no slave strobed.
- Access 0x200 with slave 2 silent → wbm_err_o exactly 16 cycles after slave stb rises; fault_code = 2; slave 2 stb drops on the same edge.
- Slave 0 drives ack and err together → master ack only; then assert i_fault_clr → fault_code = 0.
- Master drops cyc during ACTIVE, or i_rst asserted mid-wait → all stb and cyc low next cycle, no response pulse; the next transaction completes normally.
